// File: rtl/core_mem_pkg.sv
// Shared definitions for the memory-access stage: size encodings, FSM states
// and the alignment rule used to trap accesses before they reach the bus.
package core_mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  // Size 2'b10 is treated as a word, so it falls into the default arm.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: is_misaligned = 1'b0;
      SIZE_HALF: is_misaligned = addr_lo[0];
      default:   is_misaligned = (addr_lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/core_mem_align.sv
// Lane alignment for the data-memory port: byte enables and replicated store
// data on the way out, right-justified read data on the way back.
module core_mem_align
  import core_mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      i_size,
  input  logic [1:0]      i_addr_lo,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [1:0]      i_rd_addr_lo,
  input  logic [XLEN-1:0] i_rdata,
  output logic [3:0]      o_be,
  output logic [XLEN-1:0] o_wdata,
  output logic [XLEN-1:0] o_rdata
);

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    case (i_size)
      SIZE_BYTE: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      SIZE_HALF: begin
        o_be    = 4'b0011 << i_addr_lo;
        o_wdata = {2{i_wdata[15:0]}};
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
      end
    endcase
  end

  // Sign/zero extension is left to write-back; only the shift happens here.
  assign o_rdata = i_rdata >> {i_rd_addr_lo, 3'b000};

endmodule

// File: rtl/core_mem_stage.sv
// Memory-access stage: accepts one load/store from execute, runs the
// req/gnt/rvalid handshake and hands aligned load data to write-back.
module core_mem_stage
  import core_mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_mem_valid,
  input  logic            i_mem_write,
  input  logic [1:0]      i_d_size,
  input  logic            i_d_unsigned,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_wdata,
  output logic            o_mem_ready,
  output logic            o_stall,
  output logic            o_dmem_req,
  output logic            o_dmem_we,
  output logic [XLEN-1:0] o_dmem_addr,
  output logic [3:0]      o_dmem_be,
  output logic [XLEN-1:0] o_dmem_wdata,
  input  logic            i_dmem_gnt,
  input  logic            i_dmem_rvalid,
  input  logic [XLEN-1:0] i_dmem_rdata,
  output logic            o_load_valid,
  output logic [XLEN-1:0] o_data_rd_data,
  output logic [1:0]      o_d_size,
  output logic            o_d_unsigned,
  output logic            o_store_done,
  output logic            o_misaligned,
  output logic [XLEN-1:0] o_misaligned_addr
);

  // Handshake: the bus accepts a request in any cycle where req && gnt;
  // read data arrives on rvalid no earlier than the cycle after that grant.

  state_e          state_q, state_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [3:0]      be_q, be_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic            load_valid_q, load_valid_d;
  logic [XLEN-1:0] rd_data_q, rd_data_d;
  logic [1:0]      out_size_q, out_size_d;
  logic            out_uns_q, out_uns_d;
  logic            store_done_q, store_done_d;
  logic            mis_q, mis_d;
  logic [XLEN-1:0] mis_addr_q, mis_addr_d;

  logic [3:0]      al_be;
  logic [XLEN-1:0] al_wdata;
  logic [XLEN-1:0] al_rdata;
  logic            misaligned;

  core_mem_align #(.XLEN(XLEN)) u_align (
    .i_size       (i_d_size),
    .i_addr_lo    (i_addr[1:0]),
    .i_wdata      (i_wdata),
    .i_rd_addr_lo (addr_q[1:0]),
    .i_rdata      (i_dmem_rdata),
    .o_be         (al_be),
    .o_wdata      (al_wdata),
    .o_rdata      (al_rdata)
  );

  assign misaligned = is_misaligned(i_d_size, i_addr[1:0]);

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    size_d       = size_q;
    uns_d        = uns_q;
    load_valid_d = 1'b0;
    rd_data_d    = rd_data_q;
    out_size_d   = out_size_q;
    out_uns_d    = out_uns_q;
    store_done_d = 1'b0;
    mis_d        = 1'b0;
    mis_addr_d   = mis_addr_q;
    case (state_q)
      IDLE: begin
        if (i_mem_valid) begin
          if (misaligned) begin
            mis_d      = 1'b1;
            mis_addr_d = i_addr;
          end else begin
            state_d = REQ;
            req_d   = 1'b1;
            we_d    = i_mem_write;
            addr_d  = i_addr;
            be_d    = al_be;
            wdata_d = al_wdata;
            size_d  = i_d_size;
            uns_d   = i_d_unsigned;
          end
        end
      end
      REQ: begin
        if (i_dmem_gnt) begin
          req_d = 1'b0;
          we_d  = 1'b0;
          if (we_q) begin
            store_done_d = 1'b1;
            state_d      = IDLE;
          end else begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (i_dmem_rvalid) begin
          load_valid_d = 1'b1;
          rd_data_d    = al_rdata;
          out_size_d   = size_q;
          out_uns_d    = uns_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      be_q         <= 4'b0000;
      wdata_q      <= '0;
      size_q       <= SIZE_WORD;
      uns_q        <= 1'b0;
      load_valid_q <= 1'b0;
      rd_data_q    <= '0;
      out_size_q   <= SIZE_WORD;
      out_uns_q    <= 1'b0;
      store_done_q <= 1'b0;
      mis_q        <= 1'b0;
      mis_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      load_valid_q <= load_valid_d;
      rd_data_q    <= rd_data_d;
      out_size_q   <= out_size_d;
      out_uns_q    <= out_uns_d;
      store_done_q <= store_done_d;
      mis_q        <= mis_d;
      mis_addr_q   <= mis_addr_d;
    end
  end

  assign o_mem_ready       = (state_q == IDLE);
  assign o_stall           = (state_q != IDLE) || (i_mem_valid && !misaligned);
  assign o_dmem_req        = req_q;
  assign o_dmem_we         = we_q;
  assign o_dmem_addr       = {addr_q[XLEN-1:2], 2'b00};
  assign o_dmem_be         = be_q;
  assign o_dmem_wdata      = wdata_q;
  assign o_load_valid      = load_valid_q;
  assign o_data_rd_data    = rd_data_q;
  assign o_d_size          = out_size_q;
  assign o_d_unsigned      = out_uns_q;
  assign o_store_done      = store_done_q;
  assign o_misaligned      = mis_q;
  assign o_misaligned_addr = mis_addr_q;

endmodule

// File: tb/tb_core_mem_stage.sv
// Directed bench for core_mem_stage: hand-computed expectations checked with
// immediate assertions, stepping one clock at a time.
module tb_core_mem_stage;

  logic        clk;
  logic        rst_n;
  logic        mem_valid, mem_write, d_unsigned;
  logic [1:0]  d_size;
  logic [31:0] addr, wdata;
  logic        mem_ready, stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        load_valid, store_done, misaligned;
  logic [31:0] rd_data, misaligned_addr;
  logic [1:0]  o_size;
  logic        o_uns;

  int n_checks = 0;
  int n_errors = 0;

  core_mem_stage #(.XLEN(32)) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_mem_valid       (mem_valid),
    .i_mem_write       (mem_write),
    .i_d_size          (d_size),
    .i_d_unsigned      (d_unsigned),
    .i_addr            (addr),
    .i_wdata           (wdata),
    .o_mem_ready       (mem_ready),
    .o_stall           (stall),
    .o_dmem_req        (dmem_req),
    .o_dmem_we         (dmem_we),
    .o_dmem_addr       (dmem_addr),
    .o_dmem_be         (dmem_be),
    .o_dmem_wdata      (dmem_wdata),
    .i_dmem_gnt        (dmem_gnt),
    .i_dmem_rvalid     (dmem_rvalid),
    .i_dmem_rdata      (dmem_rdata),
    .o_load_valid      (load_valid),
    .o_data_rd_data    (rd_data),
    .o_d_size          (o_size),
    .o_d_unsigned      (o_uns),
    .o_store_done      (store_done),
    .o_misaligned      (misaligned),
    .o_misaligned_addr (misaligned_addr)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Drivers and checker
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_op(input logic v, input logic we, input logic [1:0] sz,
                          input logic uns, input logic [31:0] a, input logic [31:0] wd);
    mem_valid  = v;
    mem_write  = we;
    d_size     = sz;
    d_unsigned = uns;
    addr       = a;
    wdata      = wd;
  endtask

  task automatic idle_op();
    drive_op(1'b0, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_req"}, {31'h0, dmem_req}, 32'h0);
    chk({pfx, "_we"}, {31'h0, dmem_we}, 32'h0);
    chk({pfx, "_addr"}, dmem_addr, 32'h0);
    chk({pfx, "_be"}, {28'h0, dmem_be}, 32'h0);
    chk({pfx, "_wdata"}, dmem_wdata, 32'h0);
    chk({pfx, "_rd_data"}, rd_data, 32'h0);
    chk({pfx, "_mis_addr"}, misaligned_addr, 32'h0);
    chk({pfx, "_size"}, {30'h0, o_size}, 32'h3);
    chk({pfx, "_uns"}, {31'h0, o_uns}, 32'h0);
    chk({pfx, "_pulses"}, {29'h0, load_valid, store_done, misaligned}, 32'h0);
    chk({pfx, "_ready"}, {31'h0, mem_ready}, 32'h1);
  endtask

  initial begin
    rst_n       = 1'b0;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
    idle_op();
    tick();
    tick();
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    tick();

    // Word load at 0x100, unsigned, gnt immediate, rvalid one cycle later
    drive_op(1'b1, 1'b0, 2'b11, 1'b1, 32'h100, 32'h0);
    #1;
    chk("ld1_stall_accept", {31'h0, stall}, 32'h1);
    tick();
    idle_op();
    chk("ld1_req", {31'h0, dmem_req}, 32'h1);
    chk("ld1_addr", dmem_addr, 32'h100);
    chk("ld1_be", {28'h0, dmem_be}, 32'hF);
    chk("ld1_we", {31'h0, dmem_we}, 32'h0);
    chk("ld1_ready_busy", {31'h0, mem_ready}, 32'h0);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt    = 1'b0;
    chk("ld1_req_drop", {31'h0, dmem_req}, 32'h0);
    chk("ld1_stall_resp", {31'h0, stall}, 32'h1);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hDEADBEEF;
    chk("ld1_no_early_lv", {31'h0, load_valid}, 32'h0);
    tick();
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
    chk("ld1_lv_cycle3", {31'h0, load_valid}, 32'h1);
    chk("ld1_rd_data", rd_data, 32'hDEADBEEF);
    chk("ld1_size", {30'h0, o_size}, 32'h3);
    chk("ld1_uns", {31'h0, o_uns}, 32'h1);
    tick();
    chk("ld1_lv_pulse", {31'h0, load_valid}, 32'h0);
    chk("ld1_rd_hold", rd_data, 32'hDEADBEEF);

    // Byte load at 0x103, signed, rvalid two cycles after gnt
    drive_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0);
    tick();
    idle_op();
    chk("ld2_addr", dmem_addr, 32'h100);
    chk("ld2_be", {28'h0, dmem_be}, 32'h8);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    tick();
    chk("ld2_wait_lv", {31'h0, load_valid}, 32'h0);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h80AABBCC;
    tick();
    dmem_rvalid = 1'b0;
    chk("ld2_lv", {31'h0, load_valid}, 32'h1);
    chk("ld2_rd_data", rd_data, 32'h00000080);
    chk("ld2_size", {30'h0, o_size}, 32'h0);
    chk("ld2_uns", {31'h0, o_uns}, 32'h0);
    tick();

    // Half store at 0x202, gnt held off for three cycles
    drive_op(1'b1, 1'b1, 2'b01, 1'b0, 32'h202, 32'h1234ABCD);
    tick();
    idle_op();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("st_req_c%0d", i), {31'h0, dmem_req}, 32'h1);
      chk($sformatf("st_stall_c%0d", i), {31'h0, stall}, 32'h1);
      chk($sformatf("st_be_c%0d", i), {28'h0, dmem_be}, 32'hC);
      chk($sformatf("st_wdata_c%0d", i), dmem_wdata, 32'hABCDABCD);
      chk($sformatf("st_addr_c%0d", i), dmem_addr, 32'h200);
      chk($sformatf("st_we_c%0d", i), {31'h0, dmem_we}, 32'h1);
      chk($sformatf("st_done_early_c%0d", i), {31'h0, store_done}, 32'h0);
      dmem_gnt = (i == 3);
      tick();
    end
    dmem_gnt = 1'b0;
    chk("st_done", {31'h0, store_done}, 32'h1);
    chk("st_req_drop", {31'h0, dmem_req}, 32'h0);
    chk("st_stall_drop", {31'h0, stall}, 32'h0);
    tick();
    chk("st_done_pulse", {31'h0, store_done}, 32'h0);

    // Stray gnt and rvalid while idle are ignored
    dmem_gnt    = 1'b1;
    dmem_rvalid = 1'b1;
    tick();
    tick();
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    chk("stray_pulses", {30'h0, load_valid, store_done}, 32'h0);
    chk("stray_ready", {31'h0, mem_ready}, 32'h1);

    // Misaligned word load at 0x101
    drive_op(1'b1, 1'b0, 2'b11, 1'b0, 32'h101, 32'h0);
    #1;
    chk("mis_stall", {31'h0, stall}, 32'h0);
    chk("mis_ready", {31'h0, mem_ready}, 32'h1);
    tick();
    idle_op();
    chk("mis_pulse", {31'h0, misaligned}, 32'h1);
    chk("mis_addr", misaligned_addr, 32'h101);
    chk("mis_no_req", {31'h0, dmem_req}, 32'h0);
    chk("mis_ready_after", {31'h0, mem_ready}, 32'h1);
    tick();
    chk("mis_pulse_end", {31'h0, misaligned}, 32'h0);

    // Misaligned half store at 0x203
    drive_op(1'b1, 1'b1, 2'b01, 1'b0, 32'h203, 32'h55);
    tick();
    idle_op();
    chk("mis2_pulse", {31'h0, misaligned}, 32'h1);
    chk("mis2_addr", misaligned_addr, 32'h203);
    chk("mis2_no_req", {31'h0, dmem_req}, 32'h0);
    tick();

    // Load then byte store accepted in the load_valid cycle
    drive_op(1'b1, 1'b0, 2'b01, 1'b1, 32'h302, 32'h0);
    tick();
    idle_op();
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h11223344;
    tick();
    dmem_rvalid = 1'b0;
    chk("b2b_lv", {31'h0, load_valid}, 32'h1);
    chk("b2b_rd_data", rd_data, 32'h00001122);
    chk("b2b_size", {30'h0, o_size}, 32'h1);
    chk("b2b_ready", {31'h0, mem_ready}, 32'h1);
    drive_op(1'b1, 1'b1, 2'b00, 1'b0, 32'h305, 32'h000000A5);
    tick();
    idle_op();
    chk("b2b_req", {31'h0, dmem_req}, 32'h1);
    chk("b2b_we", {31'h0, dmem_we}, 32'h1);
    chk("b2b_addr", dmem_addr, 32'h304);
    chk("b2b_be", {28'h0, dmem_be}, 32'h2);
    chk("b2b_wdata", dmem_wdata, 32'hA5A5A5A5);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    chk("b2b_done", {31'h0, store_done}, 32'h1);
    tick();

    // Reset while in RESP, then a late rvalid
    drive_op(1'b1, 1'b0, 2'b11, 1'b0, 32'h400, 32'h0);
    tick();
    idle_op();
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    chk("rr_in_resp", {31'h0, mem_ready}, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rr");
    tick();
    rst_n       = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hCAFEF00D;
    tick();
    dmem_rvalid = 1'b0;
    chk("rr_no_lv", {31'h0, load_valid}, 32'h0);
    chk("rr_rd_data", rd_data, 32'h0);
    chk("rr_ready", {31'h0, mem_ready}, 32'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/core_mem_stage.md
# core_mem_stage

Memory-access stage of the pipeline. It sits between the execute stage and the write-back stage. It accepts one load or store per transaction from execute and runs a req/gnt/rvalid handshake on the data-memory port. Store data and byte enables are aligned to the word lane. Load data is right-shifted so the addressed byte or halfword lands at bit 0, then registered together with its size/sign attributes for write-back to size and sign-extend. Misaligned accesses are trapped before any bus traffic.

## Interface
Parameters:
- XLEN, 32, data/address width (only 32 supported)

Ports (all synchronous to i_clk; reset is asynchronous and active-low):
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_mem_valid  in  1  execute presents a memory op
- i_mem_write  in  1  1 = store, 0 = load
- i_d_size  in  2  00 byte, 01 half, 11 word; 10 is treated as word
- i_d_unsigned  in  1  load zero-extend flag (passed through)
- i_addr  in  XLEN  byte address
- i_wdata  in  XLEN  store data, right-justified
- o_mem_ready  out  1  stage can accept an op this cycle
- o_stall  out  1  upstream pipeline freeze
- o_dmem_req  out  1  bus request
- o_dmem_we  out  1  bus write enable
- o_dmem_addr  out  XLEN  word address ({i_addr[31:2],2'b00})
- o_dmem_be  out  4  byte enables
- o_dmem_wdata  out  XLEN  lane-replicated store data
- i_dmem_gnt  in  1  request accepted
- i_dmem_rvalid  in  1  read data valid
- i_dmem_rdata  in  XLEN  read word
- o_load_valid  out  1  one-cycle pulse; load result valid
- o_data_rd_data  out  XLEN  shifted load data to write-back
- o_d_size  out  2  size of the completed load
- o_d_unsigned  out  1  sign flag of the completed load
- o_store_done  out  1  one-cycle pulse; store granted
- o_misaligned  out  1  one-cycle pulse; misaligned access trapped
- o_misaligned_addr  out  XLEN  offending address

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE: o_mem_ready=1. An op is accepted when i_mem_valid is high.
  - Misaligned: half with addr[0]=1; word with addr[1:0]≠0. The op is not sent to the bus. Next cycle o_misaligned=1 and o_misaligned_addr=i_addr. Stay in IDLE.
  - Otherwise: latch we, addr, be, wdata, size, unsigned. Go to REQ.
- REQ: o_dmem_req=1, bus outputs held stable until i_dmem_gnt.
  - On gnt with a store: o_store_done pulses next cycle; go to IDLE.
  - On gnt with a load: go to RESP.
- RESP: wait for i_dmem_rvalid, then register i_dmem_rdata >> (8*addr[1:0]) into o_data_rd_data. o_load_valid pulses next cycle; go to IDLE.
- Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
- Store data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
- o_stall = (state≠IDLE) | (state==IDLE & i_mem_valid & aligned).
- o_data_rd_data, o_d_size and o_d_unsigned hold their values until the next load completes.

## Timing
- Reset values: state IDLE. All pulse outputs, o_dmem_req and o_dmem_we are 0. o_dmem_addr, o_dmem_be, o_dmem_wdata, o_data_rd_data and o_misaligned_addr are 0. o_d_size=2'b11, o_d_unsigned=0.
- Best-case load, with gnt in the first REQ cycle and rvalid one cycle later: accept at cycle 0, req at cycle 1, rvalid at cycle 2, o_load_valid at cycle 3.
- Best-case store: accept at cycle 0, req+gnt at cycle 1, o_store_done at cycle 2.
- Bus rule: rvalid arrives no earlier than the cycle after gnt.
- i_dmem_rvalid in IDLE or REQ is ignored.
- i_dmem_gnt outside REQ is ignored.
- Back-to-back: a new op can be accepted in the same cycle that o_load_valid or o_store_done is high.
- Reset mid-transaction aborts immediately. A late rvalid arriving after reset is ignored.

## Structure
- Package core_mem_pkg holds the size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD) and the state enum (IDLE, REQ, RESP). The write-back stage imports the same size constants.
- One combinational sub-module, core_mem_align. It produces be and wdata from (size, addr[1:0], wdata), and shifted read data from (rdata, addr[1:0]).
- The FSM and registers live in core_mem_stage.

## Test plan
- Word load at 0x100, rdata 0xDEADBEEF, gnt immediate, rvalid +1 → o_dmem_addr=0x100, be=1111, o_data_rd_data=0xDEADBEEF, o_load_valid at cycle 3.
- Byte load at 0x103, rdata 0x80AABBCC, signed → o_dmem_addr=0x100, be=1000, o_data_rd_data=0x00000080, o_d_size=00, o_d_unsigned=0.
- Half store at 0x202, wdata 0x1234ABCD, gnt delayed 3 cycles → be=1100, wdata=0xABCDABCD, req held for 4 cycles, o_stall high throughout, o_store_done one cycle after gnt.
- Word load at 0x101 → no o_dmem_req, o_misaligned pulse, o_misaligned_addr=0x101, o_mem_ready stays 1.
- i_rst_n asserted while in RESP, followed by a stray rvalid → all outputs at reset values, no o_load_valid.
- Load completes, with a store accepted in the o_load_valid cycle → store req on the next cycle, no idle bubble.
